// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiply-accumulate controller:
// FSM state encoding and default datapath widths.
package mac_seq_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 2;
  localparam int unsigned DEF_OUT_WIDTH  = 4;
  localparam int unsigned DEF_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_acc_stage.sv
// Combinational accumulate step: acc + a*b with unsigned product,
// result wrapped to OUT_WIDTH bits and the carry beyond it exposed.
module mac_acc_stage #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned OUT_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [OUT_WIDTH-1:0]  acc_i,
  output logic [OUT_WIDTH-1:0]  sum_o,
  output logic                  carry_o
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [OUT_WIDTH:0]      sum_full;

  always_comb begin
    prod     = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    sum_full = {1'b0, acc_i} + (OUT_WIDTH+1)'(prod);
    sum_o    = sum_full[OUT_WIDTH-1:0];
    carry_o  = sum_full[OUT_WIDTH];
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequential MAC controller: accepts a job (len, bias), accumulates len
// operand-pair products onto bias, then presents the result until taken.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  output logic                  busy
);

  state_e                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   ovf_q, ovf_d;

  logic [OUT_WIDTH-1:0]   stage_sum;
  logic                   stage_carry;

  mac_acc_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_acc_stage (
    .a_i     (in_a),
    .b_i     (in_b),
    .acc_i   (acc_q),
    .sum_o   (stage_sum),
    .carry_o (stage_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = OUT_WIDTH'(bias);
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // in_ready is unconditionally high here, so in_valid alone is a transfer
        if (in_valid) begin
          acc_d   = stage_sum;
          ovf_d   = ovf_q | stage_carry;
          count_d = count_q + LEN_WIDTH'(1);
          if (count_q == len_q - LEN_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == DONE);
    out_data  = (state_q == DONE) ? acc_q : '0;
    out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a job-level model (bias plus running
// integer sum of products) is compared against the DUT on every cycle.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic [1:0] bias;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_ovf;
  logic       busy;

  mac_seq_ctrl #(
    .DATA_WIDTH (2),
    .OUT_WIDTH  (4),
    .LEN_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job-level model: the exact (unwrapped) sum; result is sum mod 16 and
  // the sticky carry is set exactly when the unwrapped sum reached 16.
  int   m_sum = 0;
  logic exp_busy = 1'b0, exp_in_ready = 1'b0, exp_out_valid = 1'b0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] m_data();
    return 4'(m_sum % 16);
  endfunction

  function automatic logic m_ovf();
    return (m_sum >= 16);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_out_valid));
      if (exp_out_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data()));
        chk("out_ovf", 32'(out_ovf), 32'(m_ovf()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_busy = 1'b0; exp_in_ready = 1'b0; exp_out_valid = 1'b0;
  endtask

  task automatic start_job(input int l, input int b);
    start = 1'b1; len = 4'(l); bias = 2'(b);
    tick();
    start = 1'b0;
    // port changes after acceptance must not affect the job
    len = 4'd0; bias = 2'd3;
    m_sum = b;
    exp_busy = 1'b1;
    exp_in_ready  = (l != 0);
    exp_out_valid = (l == 0);
  endtask

  task automatic beat(input int a, input int b, input bit last);
    in_valid = 1'b1; in_a = 2'(a); in_b = 2'(b);
    tick();
    in_valid = 1'b0;
    m_sum += a * b;
    if (last) begin
      exp_in_ready = 1'b0; exp_out_valid = 1'b1;
    end
  endtask

  task automatic gap();
    in_valid = 1'b0; in_a = 2'd3; in_b = 2'd3;
    start = 1'b1; len = 4'd1; bias = 2'd1;
    tick();
    start = 1'b0;
  endtask

  task automatic take(input bit with_start);
    out_ready = 1'b1; start = with_start; len = 4'd2; bias = 2'd2;
    tick();
    out_ready = 1'b0; start = 1'b0;
    exp_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    exp_idle();
    chk_en = 1'b1;
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_ovf", 32'(out_ovf), 32'd0);
    reset = 1'b0;
    tick();

    // len=1 bias=3, beat (3,1) -> 6
    start_job(1, 3);
    beat(3, 1, 1'b1);
    chk("job1_literal", 32'(out_data), 32'd6);
    take(1'b0);
    tick();

    // len=2 bias=0, beats (1,3) gap (1,1) -> 4; start during RUN ignored
    start_job(2, 0);
    beat(1, 3, 1'b0);
    gap();
    gap();
    beat(1, 1, 1'b1);
    chk("job2_literal", 32'(out_data), 32'd4);
    take(1'b0);
    tick();

    // len=2 bias=3, beats (3,3),(3,3) -> 21 mod 16 = 5 with carry
    start_job(2, 3);
    beat(3, 3, 1'b0);
    beat(3, 3, 1'b1);
    chk("job3_literal", 32'(out_data), 32'd5);
    chk("job3_ovf_literal", 32'(out_ovf), 32'd1);
    take(1'b0);
    tick();

    // len=0 bias=2 -> result next cycle; held with start pulses ignored
    start_job(0, 2);
    chk("job4_literal", 32'(out_data), 32'd2);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; len = 4'd3; bias = 2'd1;
      tick();
    end
    start = 1'b0;
    chk("job4_hold_literal", 32'(out_data), 32'd2);
    // start in the handshake cycle is ignored; the following IDLE cycle accepts
    take(1'b1);
    tick();
    start_job(1, 0);
    beat(2, 3, 1'b1);
    chk("job5_literal", 32'(out_data), 32'd6);
    take(1'b0);
    tick();

    // reset mid-RUN, with competing start/in_valid/out_ready
    start_job(3, 0);
    beat(1, 2, 1'b0);
    reset = 1'b1; start = 1'b1; len = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    exp_idle();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_busy_literal", 32'(busy), 32'd0);
    chk("rst_out_valid_literal", 32'(out_valid), 32'd0);
    chk("rst_out_data_literal", 32'(out_data), 32'd0);
    tick();
    start_job(1, 1);
    beat(1, 1, 1'b1);
    chk("job6_literal", 32'(out_data), 32'd2);
    chk("job6_ovf_literal", 32'(out_ovf), 32'd0);
    take(1'b0);

    // reset mid-DONE discards the result
    start_job(0, 3);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    exp_idle();
    reset = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 2, operand width; unsigned.
REQ-002 Parameter OUT_WIDTH, default 4, accumulator/result width; SHALL be >= 2*DATA_WIDTH.
REQ-003 Parameter LEN_WIDTH, default 4, width of vector-length field.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request new job; sampled only in IDLE.
REQ-007 len  in  LEN_WIDTH  number of (a,b) pairs in job; sampled with start.
REQ-008 bias  in  DATA_WIDTH  addend c; sampled with start.
REQ-009 in_valid  in  1  operand pair present.
REQ-010 in_ready  out  1  block accepts operand pair.
REQ-011 in_a, in_b  in  DATA_WIDTH each  operand pair.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  OUT_WIDTH  sum(a_i*b_i) + bias, modulo 2^OUT_WIDTH.
REQ-015 out_ovf  out  1  sticky: a carry beyond OUT_WIDTH occurred during the job.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 -> latch len, acc<=zero-extended bias, count<=0, ovf<=0; next state RUN if len!=0, DONE if len==0.
REQ-019 RUN: in_ready=1 combinationally; a beat transfers only when in_valid && in_ready.
REQ-020 Per transfer: acc <= acc + (in_a*in_b); product is unsigned, 2*DATA_WIDTH bits, zero-extended; sum wraps modulo 2^OUT_WIDTH; carry-out sets ovf.
REQ-021 Per transfer count increments; transfer with count==len-1 moves state to DONE.
REQ-022 Cycles in RUN with in_valid=0 SHALL leave acc, count, ovf unchanged.
REQ-023 DONE: out_valid=1, out_data=acc, out_ovf=ovf, in_ready=0; out_data/out_ovf stable while out_ready=0.
REQ-024 DONE with out_ready=1 -> IDLE next cycle.
REQ-025 Latency: out_valid high the cycle after last accepted beat; for len==0, the cycle after start.
REQ-026 start in RUN or DONE SHALL be ignored, including the DONE cycle where out_ready=1; a new job requires start in IDLE.
REQ-027 Back-to-back jobs: minimum one IDLE cycle between result handshake and next start acceptance.
REQ-028 len, bias SHALL be held internally; changes on the ports after start have no effect on the current job.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, acc=0, count=0, ovf=0, regardless of state.
REQ-030 Outputs during/after reset: in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
REQ-031 Reset mid-RUN or mid-DONE SHALL discard the partial job; no result emitted for it.
REQ-032 reset SHALL take priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-033 Shared package holds FSM state encoding (2-bit enum IDLE/RUN/DONE) and default width constants DATA_WIDTH=2, OUT_WIDTH=4, LEN_WIDTH=4.
REQ-034 One sub-module, mac_acc_stage: combinational a*b+acc with carry-out, widths from parameters; controller holds all registers.

Verification (DATA_WIDTH=2, OUT_WIDTH=4)
REQ-035 start len=1 bias=3; beat (3,1) -> out_data=6, out_ovf=0, out_valid one cycle after beat.
REQ-036 start len=2 bias=0; beats (1,3),(1,1) with one in_valid=0 gap -> out_data=4; acc unchanged during gap.
REQ-037 start len=2 bias=3; beats (3,3),(3,3) -> out_data=5 (21 mod 16), out_ovf=1.
REQ-038 start len=0 bias=2 -> out_valid next cycle, out_data=2; hold out_ready=0 three cycles -> out_data stable, start pulses ignored.
REQ-039 start len=3; reset after first beat -> IDLE, busy=0, out_valid=0; next job len=1 bias=1 beat (1,1) -> out_data=2, out_ovf=0.
